// File: rtl/uart_arb_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding and the
// header flag constant used when the requester-ID header is enabled.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HSTART,
    HWAIT,
    DSTART,
    DWAIT
  } arb_state_t;

  // Header byte marker: MSB of a DBIT-wide frame set, all other bits clear.
  function automatic logic [31:0] hdr_flag(input int unsigned dbit);
    return 32'd1 << (dbit - 1);
  endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester handshake and UART transmitter control bundle for uart_tx_arb.
// master = requesters plus uart side, slave = the arbiter.
interface uart_tx_arb_if #(
  parameter int NREQ = 4,
  parameter int DBIT = 8
);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ*DBIT-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic [DBIT-1:0]      tx_din;
  logic                 tx_start;
  logic                 tx_done_tick;

  modport master (
    output req_valid,
    output req_data,
    output tx_done_tick,
    input  req_ready,
    input  tx_din,
    input  tx_start
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  tx_done_tick,
    output req_ready,
    output tx_din,
    output tx_start
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted valid bit searching upward
// from (last+1) mod NREQ with wrap-around.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  last,
  output logic [IDW-1:0]  winner,
  output logic            any
);

  int idx;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise paths that skip it infer a latch.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!any && valid[IDW'(idx)]) begin
        any    = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin sharing of one UART transmitter among NREQ byte producers.
// Define UART_ARB_ID_HDR_EN to prefix every byte with a requester-ID header frame.
module uart_tx_arb #(
  parameter  int NREQ = 4,
  parameter  int DBIT = 8,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_arb_if.slave   bus,
  output logic           busy,
  output logic [IDW-1:0] grant_id
);

  import uart_arb_pkg::*;

  arb_state_t      state, next_state;
  logic [IDW-1:0]  last;
  logic [IDW-1:0]  winner;
  logic            any;
  logic            accept;
  logic [DBIT-1:0] sel_data;

`ifdef UART_ARB_ID_HDR_EN
  localparam logic [DBIT-1:0] HDR_FLAG = DBIT'(hdr_flag(DBIT));
  logic [DBIT-1:0] data_q;
`endif

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .valid  (bus.req_valid),
    .last   (last),
    .winner (winner),
    .any    (any)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IDW'(i)) sel_data = bus.req_data[i*DBIT +: DBIT];
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state    = state;
    accept        = 1'b0;
    bus.req_ready = '0;
    unique case (state)
      IDLE: begin
        if (any) begin
          accept                = 1'b1;
          bus.req_ready[winner] = 1'b1;
`ifdef UART_ARB_ID_HDR_EN
          next_state = HSTART;
`else
          next_state = DSTART;
`endif
        end
      end
      HSTART: next_state = HWAIT;
      HWAIT:  if (bus.tx_done_tick) next_state = DSTART;
      DSTART: next_state = DWAIT;
      DWAIT:  if (bus.tx_done_tick) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // tx_start is registered off the state being entered, so it is high for
  // exactly the one cycle spent in HSTART or DSTART.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.tx_start <= 1'b0;
      bus.tx_din   <= '0;
      grant_id     <= '0;
      last         <= IDW'(NREQ - 1);
`ifdef UART_ARB_ID_HDR_EN
      data_q       <= '0;
`endif
    end else begin
      bus.tx_start <= (next_state == DSTART) || (next_state == HSTART);
      if (accept) begin
        grant_id <= winner;
        last     <= winner;
`ifdef UART_ARB_ID_HDR_EN
        data_q     <= sel_data;
        bus.tx_din <= HDR_FLAG | DBIT'(winner);
`else
        bus.tx_din <= sel_data;
`endif
      end
`ifdef UART_ARB_ID_HDR_EN
      if (state == HWAIT && bus.tx_done_tick) bus.tx_din <= data_q;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: frame-queue model compared every cycle,
// plus hand-written frame lists per test. Honors UART_ARB_ID_HDR_EN if defined.
module tb_uart_tx_arb;

  localparam int NREQ = 4;
  localparam int DBIT = 8;
  localparam int IDW  = 2;
  localparam logic [DBIT-1:0] HDR = 8'h80;
`ifdef UART_ARB_ID_HDR_EN
  localparam int FPG = 2;
`else
  localparam int FPG = 1;
`endif

  typedef struct {
    logic [DBIT-1:0] din;
    int              gid;
  } frame_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           busy;
  logic [IDW-1:0] grant_id;

  uart_tx_arb_if #(.NREQ(NREQ), .DBIT(DBIT)) bus ();

  uart_tx_arb #(.NREQ(NREQ), .DBIT(DBIT)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model (frame queue per grant) ----------------
  bit              m_started = 1'b0;
  bit              m_busy    = 1'b0;
  bit              m_start   = 1'b0;
  bit              m_wait    = 1'b0;
  int              m_last    = NREQ - 1;
  int              m_gid     = 0;
  logic [DBIT-1:0] m_din     = '0;
  logic [DBIT-1:0] m_q[$];

  function automatic int pick(input logic [NREQ-1:0] v, input int last);
    for (int i = last + 1; i <= last + NREQ; i++) begin
      int r;
      r = i % NREQ;
      if (v[r[IDW-1:0]]) return r;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    int w;
    if (m_busy) return '0;
    w = pick(bus.req_valid, m_last);
    if (w < 0) return '0;
    return NREQ'(1) << w;
  endfunction

  initial forever begin
    @(posedge clk);
    m_started = 1'b1;
    if (rst) begin
      m_busy = 0; m_start = 0; m_wait = 0;
      m_last = NREQ - 1; m_gid = 0; m_din = '0;
      m_q.delete();
    end else if (!m_busy) begin
      int w;
      w = pick(bus.req_valid, m_last);
      if (w >= 0) begin
        m_gid  = w;
        m_last = w;
`ifdef UART_ARB_ID_HDR_EN
        m_q.push_back(HDR | DBIT'(w));
`endif
        m_q.push_back(bus.req_data[w*DBIT +: DBIT]);
        m_din   = m_q.pop_front();
        m_busy  = 1'b1;
        m_start = 1'b1;
      end
    end else if (m_start) begin
      m_start = 1'b0;
      m_wait  = 1'b1;
    end else if (m_wait && bus.tx_done_tick) begin
      m_wait = 1'b0;
      if (m_q.size() == 0) m_busy = 1'b0;
      else begin
        m_din   = m_q.pop_front();
        m_start = 1'b1;
      end
    end
  end

  // ---------------- shared state between stimulus and compare ----------------
  frame_t lit_exp[$];
  string  lit_name;
  int     lit_req  = 0;
  int     lit_done = 0;
  int     tmo      = 0;
  bit     end_req  = 1'b0;

  // ---------------- compare process (sole owner of the counters) -------------
  int     n_run  = 0;
  int     n_fail = 0;
  int     cyc    = 0;
  frame_t sent[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (m_started) begin
      cyc++;
      check("busy",      32'(busy),          32'(m_busy));
      check("tx_start",  32'(bus.tx_start),  32'(m_start));
      check("tx_din",    32'(bus.tx_din),    32'(m_din));
      check("grant_id",  32'(grant_id),      32'(m_gid));
      check("req_ready", 32'(bus.req_ready), 32'(exp_ready()));
      if (bus.tx_start === 1'b1) sent.push_back('{bus.tx_din, int'(grant_id)});
      if (lit_done != lit_req) begin
        check({lit_name, " frame count"}, 32'(sent.size()), 32'(lit_exp.size()));
        for (int i = 0; i < sent.size() && i < lit_exp.size(); i++) begin
          check($sformatf("%s frame%0d byte", lit_name, i), 32'(sent[i].din), 32'(lit_exp[i].din));
          check($sformatf("%s frame%0d id", lit_name, i),   32'(sent[i].gid), 32'(lit_exp[i].gid));
        end
        sent.delete();
        lit_done = lit_req;
      end
      if (cyc > 20000) begin
        check("watchdog", 32'd1, 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
      end
      if (end_req && lit_done == lit_req) begin
        check("stimulus timeouts", 32'(tmo), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
      end
    end
  end

  // ---------------- stimulus ----------------
  bit keep_valid = 1'b0;

  task automatic tick();
    logic [NREQ-1:0] acc;
    @(negedge clk);
    acc = rst ? '0 : (bus.req_valid & bus.req_ready);
    @(posedge clk);
    #1;
    if (!keep_valid) bus.req_valid = bus.req_valid & ~acc;
  endtask

  task automatic wait_start();
    int t = 0;
    while (bus.tx_start !== 1'b1 && t < 64) begin
      tick();
      t++;
    end
    if (t >= 64) tmo++;
  endtask

  task automatic give_done(input int gap);
    repeat (gap) tick();
    bus.tx_done_tick = 1'b1;
    tick();
    bus.tx_done_tick = 1'b0;
  endtask

  task automatic serve(input int nframes);
    for (int f = 0; f < nframes; f++) begin
      wait_start();
      give_done(2);
    end
  endtask

  task automatic push_frame(input logic [DBIT-1:0] din, input int gid);
    lit_exp.push_back('{din, gid});
  endtask

  task automatic add(input int gid, input logic [DBIT-1:0] din);
`ifdef UART_ARB_ID_HDR_EN
    push_frame(HDR | DBIT'(gid), gid);
`endif
    push_frame(din, gid);
  endtask

  task automatic expect_frames(input string name);
    lit_name = name;
    lit_req++;
    for (int t = 0; t < 8 && lit_done != lit_req; t++) tick();
    if (lit_done != lit_req) tmo++;
    lit_exp.delete();
  endtask

  initial begin
    bus.req_valid    = '0;
    bus.req_data     = '0;
    bus.tx_done_tick = 1'b0;
    rst              = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // All four requesters held valid: strict rotation starting at 0.
    keep_valid = 1'b1;
    bus.req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.req_valid = 4'b1111;
    serve(5 * FPG);
    bus.req_valid = '0;
    keep_valid = 1'b0;
    add(0, 8'h10); add(1, 8'h11); add(2, 8'h12); add(3, 8'h13); add(0, 8'h10);
    expect_frames("round_robin");

    // Fresh reset: requesters 1 and 3 alternate, 1 first.
    rst = 1'b1; tick(); rst = 1'b0;
    keep_valid = 1'b1;
    bus.req_data  = {8'h23, 8'h00, 8'h21, 8'h00};
    bus.req_valid = 4'b1010;
    serve(3 * FPG);
    bus.req_valid = '0;
    keep_valid = 1'b0;
    add(1, 8'h21); add(3, 8'h23); add(1, 8'h21);
    expect_frames("fairness");

    // Single one-shot request on requester 2.
    bus.req_data[2*DBIT +: DBIT] = 8'h5A;
    bus.req_valid = 4'b0100;
    serve(FPG);
    add(2, 8'h5A);
    expect_frames("single");

    // Done ticks outside the wait states must be ignored.
    bus.tx_done_tick = 1'b1;
    tick(); tick();
    bus.tx_done_tick = 1'b0;
    bus.req_data[0 +: DBIT] = 8'h3C;
    bus.req_valid = 4'b0001;
    wait_start();
    bus.tx_done_tick = 1'b1;
    tick();
    bus.tx_done_tick = 1'b0;
    repeat (3) tick();
    give_done(1);
    serve(FPG - 1);
    add(0, 8'h3C);
    expect_frames("spurious_done");

    // Reset while waiting for the first frame to finish.
    bus.req_data[3*DBIT +: DBIT] = 8'h77;
    bus.req_valid = 4'b1000;
    wait_start();
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
`ifdef UART_ARB_ID_HDR_EN
    push_frame(8'h83, 3);
`else
    push_frame(8'h77, 3);
`endif
    expect_frames("reset_mid_frame");
    bus.req_data[0 +: 2*DBIT] = {8'hA1, 8'hA0};
    bus.req_valid = 4'b0011;
    serve(FPG);
    bus.req_valid = '0;
    add(0, 8'hA0);
    expect_frames("post_reset_priority");

`ifdef UART_ARB_ID_HDR_EN
    // Header frame carries 0x80 | id ahead of the data byte.
    bus.req_data[3*DBIT +: DBIT] = 8'hC3;
    bus.req_valid = 4'b1000;
    serve(2);
    push_frame(8'h83, 3); push_frame(8'hC3, 3);
    expect_frames("header");
`endif

    repeat (2) tick();
    end_req = 1'b1;
  end

endmodule
